alu_fpga_sequencer: RTL and testbench
=====================================

Name: alu_fpga_sequencer

Overview:
- Operator-input stage that sits directly upstream of the ALU in the FPGA bring-up wrapper.
- Debounces the four push-buttons and loads op1, op2 and the opcode from the switches under a state machine. It then drives the ALU and latches its result and flags for the display logic.
- Replaces the direct switch-to-ALU wiring. Operands become full 32-bit sign-extended values, and results stay stable after the switches change.

Parameters:
- DB_CYCLES, 500000, stable cycles required before a key level is accepted (10 ms at 50 MHz). Benches use 4.
- DW, 32, operand and result width.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- key_n  in  4  raw push-buttons, active-low, asynchronous: [0] load op1, [1] load op2, [2] execute, [3] clear
- sw  in  18  raw switches: [15:0] operand value, [16] operand sign, [3:0] opcode on execute
- alu_op1  out  DW  to ALU op1
- alu_op2  out  DW  to ALU op2
- alu_opcode  out  4  to ALU opcode
- alu_res  in  DW  ALU result, combinational from alu_op1/alu_op2/alu_opcode
- alu_flags  in  3  {v,n,z} from ALU
- res_q  out  DW  latched result
- flags_q  out  3  latched {v,n,z}
- res_valid  out  1  res_q/flags_q correspond to the current operands and opcode
- state_o  out  3  current FSM state encoding, for LEDs
- err  out  1  one-cycle pulse on an illegal key press

Behaviour:
- Reset values: RST high at a rising CLK edge clears all registers and debouncers.
  - alu_op1, alu_op2, alu_opcode, res_q, flags_q = 0.
  - res_valid = 0, err = 0, state = EMPTY.
- Input synchronisation: key_n and sw each pass through a 2-flop synchroniser. sw is used only after synchronisation.
- Debounce, per key:
  - A counter resets whenever the synced level differs from the accepted level.
  - When the counter reaches DB_CYCLES-1 with the level unchanged, the accepted level updates.
  - A transition of the accepted level from released to pressed emits a one-cycle press pulse.
  - Release emits nothing.
  - A glitch shorter than DB_CYCLES is never accepted.
- Operand value: {{15{sw[16]}}, sw[16], sw[15:0]}, sampled in the cycle of the pulse.
- Priority when several pulses occur in one cycle: clear > execute > load op2 > load op1. Only the winning pulse acts. The others are dropped with no err.
- FSM states: EMPTY, A_LOADED, AB_LOADED, EXEC, DONE.
  - EMPTY:
    - load op1: op1 is written, go to A_LOADED.
    - load op2 or execute: err pulse, stay.
  - A_LOADED:
    - load op1: op1 is rewritten, stay.
    - load op2: op2 is written, go to AB_LOADED.
    - execute: err pulse, stay.
  - AB_LOADED:
    - load op1 or load op2: that operand is rewritten, stay.
    - execute: alu_opcode <= sw[3:0], go to EXEC.
  - EXEC:
    - Lasts exactly one cycle.
    - res_q <= alu_res, flags_q <= alu_flags, res_valid <= 1, go to DONE.
    - Every pulse arriving in this cycle except clear is ignored, with no err.
  - DONE:
    - load op1: op1 is rewritten, op2 is cleared to 0, res_valid <= 0, go to A_LOADED.
    - load op2: op2 is rewritten, res_valid <= 0, go to AB_LOADED.
    - execute: alu_opcode is reloaded, res_valid <= 0, go to EXEC (re-run).
- Clear, from any state including EXEC: all datapath registers go to their reset values and state goes to EMPTY on the next edge. err stays 0.
- Latency: execute pulse at edge t.
  - alu_opcode updates at t+1 (state EXEC).
  - res_q and res_valid update at t+2.
  - The ALU therefore gets one full cycle to settle.
- alu_op1, alu_op2 and alu_opcode are registered and change only on the writes listed above.
- res_q holds its value when the switches change. Only DONE-state actions or clear modify it.
- Reset during a debounce or during EXEC has priority: no partial result is captured.
- The ALU is not modified.

Decomposition:
- Package alu_seq_pkg:
  - typedef enum logic [2:0] seq_state_t {EMPTY, A_LOADED, AB_LOADED, EXEC, DONE}.
  - Key index constants KEY_LDA=0, KEY_LDB=1, KEY_EXE=2, KEY_CLR=3.
- Sub-module key_debounce:
  - Parameter DB_CYCLES.
  - Ports CLK, RST, raw_n, pressed, press_pulse.
  - Includes its own 2-flop synchroniser.
  - Instantiated four times.
- The FPGA wrapper is updated to instantiate alu_fpga_sequencer between the switches/keys and the ALU. HEX displays are driven from res_q.

Test Plan:
All scenarios use DB_CYCLES=4.
- Reset: hold RST 3 cycles, then release → all outputs 0, state_o=EMPTY, err=0.
- Debounce: 2-cycle low glitch on key_n[0] → no op1 load. A 10-cycle low hold → exactly one load.
- Basic add:
  - sw=0x00005, press key 0 → alu_op1=0x00000005.
  - sw=0x1FFFD, press key 1 → alu_op2=0xFFFFFFFD.
  - sw[3:0]=ADD, press key 2 → alu_opcode updates exactly 1 cycle after the pulse; res_q=0x00000002, res_valid=1 exactly 2 cycles after the pulse; flags_q z=0, n=0.
- Illegal sequence:
  - From EMPTY, press execute → err high for 1 cycle, state stays EMPTY.
  - Press key 1 → err pulse again.
- Simultaneous and re-run:
  - In DONE, execute and load op1 pulse in the same cycle → re-run wins, op1 unchanged.
  - Then change sw after DONE → res_q unchanged.
- Clear mid-operation: clear in the EXEC cycle → next cycle state EMPTY, res_valid=0, res_q=0, alu_op1=alu_op2=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and key indices for the operator-input sequencer in front of the ALU.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    EMPTY     = 3'd0,
    A_LOADED  = 3'd1,
    AB_LOADED = 3'd2,
    EXEC      = 3'd3,
    DONE      = 3'd4
  } seq_state_t;

  localparam int KEY_LDA = 0;
  localparam int KEY_LDB = 1;
  localparam int KEY_EXE = 2;
  localparam int KEY_CLR = 3;

  // Switch field carrying the operand: sign bit sw[16] plus magnitude sw[15:0]
  localparam int OPND_W = 17;

endpackage

// File: rtl/alu_fpga_sequencer_if.sv
// Operand/opcode bus between the sequencer (master) and the combinational ALU (slave).
interface alu_fpga_sequencer_if #(
  parameter int DW = 32
);
  logic [DW-1:0] alu_op1;
  logic [DW-1:0] alu_op2;
  logic [3:0]    alu_opcode;
  logic [DW-1:0] alu_res;
  logic [2:0]    alu_flags;

  modport master (
    output alu_op1, alu_op2, alu_opcode,
    input  alu_res, alu_flags
  );

  modport slave (
    input  alu_op1, alu_op2, alu_opcode,
    output alu_res, alu_flags
  );
endinterface

// File: rtl/key_debounce.sv
// Synchronises one active-low push-button, debounces it and emits a one-cycle pulse on press.
module key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw_n,
  output logic pressed,
  output logic press_pulse
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          level;

  assign level = ~sync_p1;

  // Synchronisers idle at the released level so reset never produces a press
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_p0     <= 1'b1;
      sync_p1     <= 1'b1;
      cnt         <= '0;
      pressed     <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync_p0     <= raw_n;
      sync_p1     <= sync_p0;
      press_pulse <= 1'b0;
      if (level == pressed) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt         <= '0;
        pressed     <= level;
        press_pulse <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_fpga_sequencer.sv
// Loads sign-extended operands and an opcode from the switches under key control,
// runs the external ALU for one settling cycle and holds its result for the display.
module alu_fpga_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int DW        = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [3:0]                  key_n,
  input  logic [17:0]                 sw,
  alu_fpga_sequencer_if.master        alu,
  output logic [DW-1:0]               res_q,
  output logic [2:0]                  flags_q,
  output logic                        res_valid,
  output logic [2:0]                  state_o,
  output logic                        err
);
  logic [17:0]          sw_p0;
  logic [17:0]          sw_p1;
  logic [3:0]           pressed;
  logic [3:0]           pulse;
  logic                 w_clr, w_exe, w_ldb, w_lda;
  logic signed [DW-1:0] operand;
  logic                 unused_bits;

  seq_state_t           state_q, state_d;
  logic [DW-1:0]        op1_q, op1_d, op2_q, op2_d, res_d;
  logic [3:0]           opc_q, opc_d;
  logic [2:0]           flags_d;
  logic                 valid_d, err_d;

  function automatic logic signed [DW-1:0] sign_extend(input logic [OPND_W-1:0] v);
    return {{(DW-OPND_W){v[OPND_W-1]}}, v};
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key (
      .CLK         (CLK),
      .RST         (RST),
      .raw_n       (key_n[k]),
      .pressed     (pressed[k]),
      .press_pulse (pulse[k])
    );
  end

  // Switch synchroniser stage
  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= sw;
      sw_p1 <= sw_p0;
    end
  end

  assign unused_bits = ^{sw_p1[17], pressed};
  assign operand     = sign_extend(sw_p1[OPND_W-1:0]);

  // Only the highest-priority pulse of a cycle acts; the rest are dropped silently
  assign w_clr = pulse[KEY_CLR];
  assign w_exe = pulse[KEY_EXE] & ~w_clr;
  assign w_ldb = pulse[KEY_LDB] & ~pulse[KEY_EXE] & ~w_clr;
  assign w_lda = pulse[KEY_LDA] & ~pulse[KEY_LDB] & ~pulse[KEY_EXE] & ~w_clr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= EMPTY;
      op1_q     <= '0;
      op2_q     <= '0;
      opc_q     <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      opc_q     <= opc_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      res_valid <= valid_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opc_d   = opc_q;
    res_d   = res_q;
    flags_d = flags_q;
    valid_d = res_valid;
    err_d   = 1'b0;
    if (w_clr) begin
      state_d = EMPTY;
      op1_d   = '0;
      op2_d   = '0;
      opc_d   = '0;
      res_d   = '0;
      flags_d = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (w_lda) begin
            op1_d   = operand;
            state_d = A_LOADED;
          end else if (w_ldb || w_exe) begin
            err_d = 1'b1;
          end
        end
        A_LOADED: begin
          if (w_lda) begin
            op1_d = operand;
          end else if (w_ldb) begin
            op2_d   = operand;
            state_d = AB_LOADED;
          end else if (w_exe) begin
            err_d = 1'b1;
          end
        end
        AB_LOADED: begin
          if (w_lda) begin
            op1_d = operand;
          end else if (w_ldb) begin
            op2_d = operand;
          end else if (w_exe) begin
            opc_d   = sw_p1[3:0];
            state_d = EXEC;
          end
        end
        // ALU has had a full cycle on stable registered inputs
        EXEC: begin
          res_d   = alu.alu_res;
          flags_d = alu.alu_flags;
          valid_d = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          if (w_lda) begin
            op1_d   = operand;
            op2_d   = '0;
            valid_d = 1'b0;
            state_d = A_LOADED;
          end else if (w_ldb) begin
            op2_d   = operand;
            valid_d = 1'b0;
            state_d = AB_LOADED;
          end else if (w_exe) begin
            opc_d   = sw_p1[3:0];
            valid_d = 1'b0;
            state_d = EXEC;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign alu.alu_op1    = op1_q;
  assign alu.alu_op2    = op2_q;
  assign alu.alu_opcode = opc_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_alu_fpga_sequencer.sv
// Directed bench for alu_fpga_sequencer with a small behavioural ALU on the slave side.
module tb_alu_fpga_sequencer;
  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  key_n;
  logic [17:0] sw;
  logic [31:0] res_q;
  logic [2:0]  flags_q;
  logic        res_valid;
  logic [2:0]  state_o;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;

  always #5 CLK = ~CLK;

  alu_fpga_sequencer_if #(.DW(32)) bus ();

  alu_fpga_sequencer #(.DB_CYCLES(4), .DW(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .key_n     (key_n),
    .sw        (sw),
    .alu       (bus.master),
    .res_q     (res_q),
    .flags_q   (flags_q),
    .res_valid (res_valid),
    .state_o   (state_o),
    .err       (err)
  );

  // Bench ALU: 1 ADD, 2 SUB, 3 SHL; flags {v,n,z}
  logic [31:0] a, b, r;
  logic        v;
  always_comb begin
    a = bus.alu_op1;
    b = bus.alu_op2;
    r = 32'h0;
    v = 1'b0;
    case (bus.alu_opcode)
      4'd1: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd2: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd3: begin r = a << b[4:0]; v = (r[31] != a[31]); end
      default: begin r = 32'h0; v = 1'b0; end
    endcase
    bus.alu_res   = r;
    bus.alu_flags = {v, r[31], (r == 32'h0)};
  end

  always @(posedge CLK) if (err === 1'b1) err_cnt <= err_cnt + 1;

  typedef struct {
    int          key;
    logic [17:0] swv;
    logic [2:0]  st;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  opc;
    logic [31:0] res;
    logic [2:0]  flg;
    logic        vld;
    int          errd;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_sw(input logic [17:0] val);
    @(negedge CLK);
    sw = val;
    repeat (3) @(negedge CLK);
  endtask

  task automatic press(input int k, input int hold);
    @(negedge CLK);
    key_n[k] = 1'b0;
    repeat (hold) @(negedge CLK);
    key_n[k] = 1'b1;
    repeat (10) @(negedge CLK);
  endtask

  task automatic chk_all(input string p, input logic [2:0] st, input logic [31:0] op1,
                         input logic [31:0] op2, input logic [3:0] opc, input logic [31:0] res,
                         input logic [2:0] flg, input logic vld);
    chk({p, "_state"}, {29'd0, state_o}, {29'd0, st});
    chk({p, "_op1"}, bus.alu_op1, op1);
    chk({p, "_op2"}, bus.alu_op2, op2);
    chk({p, "_opcode"}, {28'd0, bus.alu_opcode}, {28'd0, opc});
    chk({p, "_res"}, res_q, res);
    chk({p, "_flags"}, {29'd0, flags_q}, {29'd0, flg});
    chk({p, "_valid"}, {31'd0, res_valid}, {31'd0, vld});
  endtask

  initial begin
    int e0;
    vecs[0]  = '{2, 18'h00000, 3'd0, 32'h00000000, 32'h00000000, 4'h0, 32'h00000000, 3'b000, 1'b0, 1};
    vecs[1]  = '{1, 18'h00003, 3'd0, 32'h00000000, 32'h00000000, 4'h0, 32'h00000000, 3'b000, 1'b0, 1};
    vecs[2]  = '{0, 18'h00005, 3'd1, 32'h00000005, 32'h00000000, 4'h0, 32'h00000000, 3'b000, 1'b0, 0};
    vecs[3]  = '{2, 18'h00005, 3'd1, 32'h00000005, 32'h00000000, 4'h0, 32'h00000000, 3'b000, 1'b0, 1};
    vecs[4]  = '{1, 18'h1FFFD, 3'd2, 32'h00000005, 32'hFFFFFFFD, 4'h0, 32'h00000000, 3'b000, 1'b0, 0};
    vecs[5]  = '{2, 18'h00001, 3'd4, 32'h00000005, 32'hFFFFFFFD, 4'h1, 32'h00000002, 3'b000, 1'b1, 0};
    vecs[6]  = '{1, 18'h00005, 3'd2, 32'h00000005, 32'h00000005, 4'h1, 32'h00000002, 3'b000, 1'b0, 0};
    vecs[7]  = '{2, 18'h00002, 3'd4, 32'h00000005, 32'h00000005, 4'h2, 32'h00000000, 3'b001, 1'b1, 0};
    vecs[8]  = '{0, 18'h10000, 3'd1, 32'hFFFF0000, 32'h00000000, 4'h2, 32'h00000000, 3'b001, 1'b0, 0};
    vecs[9]  = '{1, 18'h0FFFF, 3'd2, 32'hFFFF0000, 32'h0000FFFF, 4'h2, 32'h00000000, 3'b001, 1'b0, 0};
    vecs[10] = '{2, 18'h00001, 3'd4, 32'hFFFF0000, 32'h0000FFFF, 4'h1, 32'hFFFFFFFF, 3'b010, 1'b1, 0};
    vecs[11] = '{2, 18'h00003, 3'd4, 32'hFFFF0000, 32'h0000FFFF, 4'h3, 32'h00000000, 3'b101, 1'b1, 0};
    vecs[12] = '{3, 18'h00000, 3'd0, 32'h00000000, 32'h00000000, 4'h0, 32'h00000000, 3'b000, 1'b0, 0};

    RST   = 1'b1;
    key_n = 4'hF;
    sw    = 18'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk_all("reset", 3'd0, 32'h0, 32'h0, 4'h0, 32'h0, 3'b000, 1'b0);
    chk("reset_err", {31'd0, err}, 32'd0);

    // Two-cycle glitch must not be accepted
    set_sw(18'h00007);
    e0 = err_cnt;
    press(0, 2);
    chk("glitch_state", {29'd0, state_o}, 32'd0);
    chk("glitch_op1", bus.alu_op1, 32'h0);
    chk("glitch_err", err_cnt - e0, 32'd0);

    for (int i = 0; i < 13; i++) begin
      set_sw(vecs[i].swv);
      e0 = err_cnt;
      press(vecs[i].key, 10);
      chk_all($sformatf("row%0d", i), vecs[i].st, vecs[i].op1, vecs[i].op2, vecs[i].opc,
              vecs[i].res, vecs[i].flg, vecs[i].vld);
      chk($sformatf("row%0d_errcount", i), err_cnt - e0, vecs[i].errd);
    end

    // Cycle-exact execute latency
    set_sw(18'h00005);
    press(0, 10);
    set_sw(18'h1FFFD);
    press(1, 10);
    set_sw(18'h00001);
    e0 = err_cnt;
    key_n[2] = 1'b0;
    repeat (6) @(negedge CLK);
    chk("lat_t_opcode", {28'd0, bus.alu_opcode}, 32'h0);
    chk("lat_t_state", {29'd0, state_o}, 32'd2);
    @(negedge CLK);
    chk("lat_t1_opcode", {28'd0, bus.alu_opcode}, 32'h1);
    chk("lat_t1_state", {29'd0, state_o}, 32'd3);
    chk("lat_t1_valid", {31'd0, res_valid}, 32'd0);
    @(negedge CLK);
    chk_all("lat_t2", 3'd4, 32'h5, 32'hFFFFFFFD, 4'h1, 32'h2, 3'b000, 1'b1);
    key_n[2] = 1'b1;
    repeat (10) @(negedge CLK);
    chk("lat_errcount", err_cnt - e0, 32'd0);

    // Execute and load op1 together in DONE: re-run wins
    set_sw(18'h00002);
    e0 = err_cnt;
    key_n = 4'b1010;
    repeat (10) @(negedge CLK);
    key_n = 4'hF;
    repeat (10) @(negedge CLK);
    chk_all("simul", 3'd4, 32'h5, 32'hFFFFFFFD, 4'h2, 32'h8, 3'b000, 1'b1);
    chk("simul_errcount", err_cnt - e0, 32'd0);
    set_sw(18'h1FFFF);
    repeat (4) @(negedge CLK);
    chk_all("swchg", 3'd4, 32'h5, 32'hFFFFFFFD, 4'h2, 32'h8, 3'b000, 1'b1);

    // Clear arriving in the EXEC cycle
    set_sw(18'h00001);
    e0 = err_cnt;
    key_n[2] = 1'b0;
    @(negedge CLK);
    key_n[3] = 1'b0;
    repeat (6) @(negedge CLK);
    chk("clrexec_in_exec", {29'd0, state_o}, 32'd3);
    @(negedge CLK);
    chk_all("clrexec", 3'd0, 32'h0, 32'h0, 4'h0, 32'h0, 3'b000, 1'b0);
    key_n = 4'hF;
    repeat (10) @(negedge CLK);
    chk_all("clrexec_hold", 3'd0, 32'h0, 32'h0, 4'h0, 32'h0, 3'b000, 1'b0);
    chk("clrexec_errcount", err_cnt - e0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
